// File: rtl/fp_minmax_stream.sv
// IEEE-754 single min/max selector: 2-stage a<=b compare into an FWFT output FIFO, result visible 3 cycles after accept.
// in_ready is a registered-credit check over FIFO occupancy plus in-flight ops, so the pipe never stalls.
module fp_minmax_stream #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [1:0]  bos,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        out_le,
  output logic        out_unord
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = CNT_W + 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  bos;
    logic        a_nan;
    logic        b_nan;
    logic        both_zero;
  } s1_t;

  typedef struct packed {
    logic [31:0] res;
    logic        le;
    logic        unord;
  } ent_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction

  logic             s1_v;
  s1_t              s1_dat;
  logic             s2_v;
  ent_t             s2_dat;
  ent_t             mem [FIFO_DEPTH];
  ent_t             last_dat;
  ent_t             head_dat;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [SW-1:0]    inflight;
  logic             accept;
  logic             push;
  logic             pop;
  logic             cmp_le;
  logic             cmp_unord;
  logic [31:0]      cmp_sel;

  // Credit counts ops already committed to the FIFO; a pop only frees a slot next cycle.
  assign inflight = SW'(fifo_count) + SW'(s1_v) + SW'(s2_v);
  assign in_ready = !rst && (inflight < SW'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= accept;
      s2_v <= s1_v;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_dat.a         <= operand_a;
      s1_dat.b         <= operand_b;
      s1_dat.bos       <= bos;
      s1_dat.a_nan     <= is_nan(operand_a);
      s1_dat.b_nan     <= is_nan(operand_b);
      s1_dat.both_zero <= ((operand_a[30:0] | operand_b[30:0]) == 31'd0);
    end
    if (s1_v) begin
      s2_dat.res   <= cmp_sel;
      s2_dat.le    <= cmp_le;
      s2_dat.unord <= cmp_unord;
    end
  end

  // Sign-magnitude ordering: negative magnitudes compare reversed, +0 equals -0.
  always_comb begin
    cmp_unord = s1_dat.a_nan || s1_dat.b_nan;
    cmp_le    = 1'b0;
    if (cmp_unord)
      cmp_le = 1'b0;
    else if (s1_dat.both_zero)
      cmp_le = 1'b1;
    else if (s1_dat.a[31] != s1_dat.b[31])
      cmp_le = s1_dat.a[31];
    else if (!s1_dat.a[31])
      cmp_le = (s1_dat.a[30:0] <= s1_dat.b[30:0]);
    else
      cmp_le = (s1_dat.a[30:0] >= s1_dat.b[30:0]);

    case (s1_dat.bos)
      2'b10:   cmp_sel = cmp_le ? s1_dat.b : s1_dat.a;
      2'b01:   cmp_sel = cmp_le ? s1_dat.a : s1_dat.b;
      default: cmp_sel = 32'h0;
    endcase
  end

  assign push      = s2_v;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr] <= s2_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      last_dat   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        last_dat <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // When empty the outputs keep showing the most recently popped entry.
  assign head_dat  = out_valid ? mem[rd_ptr] : last_dat;
  assign result    = head_dat.res;
  assign out_le    = head_dat.le;
  assign out_unord = head_dat.unord;

endmodule
